// File: rtl/fq_pkg.sv
// Shared types and constants for the per-flow store-and-forward ingress buffer.
package fq_pkg;

    localparam int FQ_WORD_W  = 64;
    localparam int FQ_LEN_LSB = 0;
    localparam int FQ_LEN_W   = 8;

    typedef logic [FQ_WORD_W-1:0] fq_word_t;
    typedef logic [FQ_LEN_W-1:0]  fq_len_t;

    typedef enum logic [1:0] {
        IDLE,
        STORE,
        DROP
    } fq_ff_state_t;

    // Packet length (in words, header included) carried by a header word.
    function automatic fq_len_t fq_hdr_len(input fq_word_t word);
        return word[FQ_LEN_LSB +: FQ_LEN_W];
    endfunction

endpackage

// File: rtl/fq_ram.sv
// Simple dual-port word store: one synchronous write port, one asynchronous
// (show-ahead) read port.
module fq_ram
    import fq_pkg::*;
#(
    parameter int DEPTH_LOG2 = 6
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] wr_addr,
    input  fq_word_t              wr_data,
    input  logic [DEPTH_LOG2-1:0] rd_addr,
    output fq_word_t              rd_data
);

    fq_word_t mem [2**DEPTH_LOG2];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fq_flow_fifo.sv
// Per-flow packet buffer: words become readable only after their whole packet
// has been committed; oversize or malformed packets are dropped whole.
module fq_flow_fifo
    import fq_pkg::*;
#(
    parameter int DEPTH_LOG2 = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic                 in_sop,
    input  logic                 in_eop,
    input  logic [FQ_WORD_W-1:0] in_data,
    input  logic                 fifo_rdreq,
    output logic                 fifo_empty,
    output logic [FQ_WORD_W-1:0] fifo_data,
    output logic [DEPTH_LOG2:0]  pkt_count,
    output logic [15:0]          drop_count,
    output logic                 err_len
);

    localparam int PW = DEPTH_LOG2 + 1;
    localparam logic [PW-1:0] DEPTH   = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [PW-1:0] PTR_ONE = PW'(1);
    localparam fq_len_t       LEN_ONE = FQ_LEN_W'(1);

    fq_ff_state_t state_reg, state_next;
    fq_len_t      remaining_reg, remaining_next;
    logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PW-1:0] commit_ptr_reg, commit_ptr_next;
    logic [PW-1:0] rd_ptr_reg;
    fq_len_t      rd_left_reg;
    logic [DEPTH_LOG2:0] pkt_count_reg;
    logic [15:0]  drop_count_reg;
    logic         err_len_reg;

    logic                  ram_we;
    logic [DEPTH_LOG2-1:0] ram_wr_addr;
    fq_word_t              ram_rd_data;

    fq_len_t       hdr_len;
    logic [PW-1:0] hdr_free;
    logic          hdr_fits;
    logic [1:0]    drop_add;
    logic          err_set;
    logic          commit_inc;
    logic          pop;
    logic          hdr_pop;
    logic [16:0]   drop_sum;

    fq_ram #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_ram (
        .clk     (clk),
        .we      (ram_we),
        .wr_addr (ram_wr_addr),
        .wr_data (in_data),
        .rd_addr (rd_ptr_reg[DEPTH_LOG2-1:0]),
        .rd_data (ram_rd_data)
    );

    // A header always lands at commit_ptr (any aborted packet is rolled back
    // first), so its space check is taken against the committed fill level.
    assign hdr_len  = fq_hdr_len(in_data);
    assign hdr_free = DEPTH - (commit_ptr_reg - rd_ptr_reg);
    assign hdr_fits = (hdr_len != '0) && (32'(hdr_len) <= 32'(hdr_free));

    always_comb begin
        state_next      = state_reg;
        remaining_next  = remaining_reg;
        wr_ptr_next     = wr_ptr_reg;
        commit_ptr_next = commit_ptr_reg;
        ram_we          = 1'b0;
        ram_wr_addr     = wr_ptr_reg[DEPTH_LOG2-1:0];
        drop_add        = 2'd0;
        err_set         = 1'b0;
        commit_inc      = 1'b0;

        if (in_valid && in_sop) begin
            wr_ptr_next = commit_ptr_reg;
            if (state_reg == STORE) begin
                err_set  = 1'b1;
                drop_add = 2'd1;
            end
            if (!hdr_fits) begin
                drop_add   = drop_add + 2'd1;
                state_next = in_eop ? IDLE : DROP;
            end else begin
                ram_we      = 1'b1;
                ram_wr_addr = commit_ptr_reg[DEPTH_LOG2-1:0];
                if (hdr_len == LEN_ONE) begin
                    if (in_eop) begin
                        commit_ptr_next = commit_ptr_reg + PTR_ONE;
                        wr_ptr_next     = commit_ptr_reg + PTR_ONE;
                        commit_inc      = 1'b1;
                        state_next      = IDLE;
                    end else begin
                        err_set    = 1'b1;
                        drop_add   = drop_add + 2'd1;
                        state_next = DROP;
                    end
                end else if (in_eop) begin
                    err_set    = 1'b1;
                    drop_add   = drop_add + 2'd1;
                    state_next = IDLE;
                end else begin
                    wr_ptr_next    = commit_ptr_reg + PTR_ONE;
                    remaining_next = hdr_len - LEN_ONE;
                    state_next     = STORE;
                end
            end
        end else if (in_valid) begin
            case (state_reg)
                STORE: begin
                    ram_we         = 1'b1;
                    remaining_next = remaining_reg - LEN_ONE;
                    if (in_eop && remaining_reg == LEN_ONE) begin
                        commit_ptr_next = wr_ptr_reg + PTR_ONE;
                        wr_ptr_next     = wr_ptr_reg + PTR_ONE;
                        commit_inc      = 1'b1;
                        state_next      = IDLE;
                    end else if (in_eop || remaining_reg == LEN_ONE) begin
                        wr_ptr_next = commit_ptr_reg;
                        err_set     = 1'b1;
                        drop_add    = 2'd1;
                        state_next  = in_eop ? IDLE : DROP;
                    end else begin
                        wr_ptr_next = wr_ptr_reg + PTR_ONE;
                    end
                end
                DROP: begin
                    if (in_eop) begin
                        state_next = IDLE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // rd_left counts words still to pop in the packet being read; zero means
    // the head word is a header.
    assign pop      = fifo_rdreq && !fifo_empty;
    assign hdr_pop  = pop && (rd_left_reg == '0);
    assign drop_sum = {1'b0, drop_count_reg} + 17'(drop_add);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            remaining_reg  <= '0;
            wr_ptr_reg     <= '0;
            commit_ptr_reg <= '0;
            rd_ptr_reg     <= '0;
            rd_left_reg    <= '0;
            pkt_count_reg  <= '0;
            drop_count_reg <= '0;
            err_len_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            remaining_reg  <= remaining_next;
            wr_ptr_reg     <= wr_ptr_next;
            commit_ptr_reg <= commit_ptr_next;
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            end
            if (hdr_pop) begin
                rd_left_reg <= fq_hdr_len(ram_rd_data) - LEN_ONE;
            end else if (pop) begin
                rd_left_reg <= rd_left_reg - LEN_ONE;
            end
            if (commit_inc && !hdr_pop) begin
                pkt_count_reg <= pkt_count_reg + 1'b1;
            end else if (hdr_pop && !commit_inc) begin
                pkt_count_reg <= pkt_count_reg - 1'b1;
            end
            drop_count_reg <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
            if (err_set) begin
                err_len_reg <= 1'b1;
            end
        end
    end

    assign fifo_empty = (commit_ptr_reg == rd_ptr_reg);
    assign fifo_data  = fifo_empty ? '0 : ram_rd_data;
    assign pkt_count  = pkt_count_reg;
    assign drop_count = drop_count_reg;
    assign err_len    = err_len_reg;

endmodule

// File: tb/tb_fq_flow_fifo.sv
// Scoreboard bench for fq_flow_fifo at DEPTH_LOG2=4 (16-word buffer).
module tb_fq_flow_fifo;

    localparam int DL = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_sop = 1'b0;
    logic        in_eop = 1'b0;
    logic [63:0] in_data = '0;
    logic        fifo_rdreq = 1'b0;
    logic        fifo_empty;
    logic [63:0] fifo_data;
    logic [DL:0] pkt_count;
    logic [15:0] drop_count;
    logic        err_len;

    int errors = 0;
    int checks = 0;
    int exp_drops = 0;
    logic [63:0] exp_q[$];

    fq_flow_fifo #(.DEPTH_LOG2(DL)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_sop     (in_sop),
        .in_eop     (in_eop),
        .in_data    (in_data),
        .fifo_rdreq (fifo_rdreq),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .pkt_count  (pkt_count),
        .drop_count (drop_count),
        .err_len    (err_len)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
        $fatal(1, "timeout");
    end

    function automatic logic [63:0] mkw(input logic [7:0] tag, input int idx, input logic [7:0] len);
        return {tag, 48'(idx), len};
    endfunction

    task automatic send(input logic sop, input logic eop, input logic [63:0] d);
        in_valid = 1'b1;
        in_sop   = sop;
        in_eop   = eop;
        in_data  = d;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_sop   = 1'b0;
        in_eop   = 1'b0;
        in_data  = '0;
    endtask

    // Sends nwords words framed as one packet whose header claims LEN=len.
    task automatic send_pkt(input logic [7:0] tag, input logic [7:0] len, input int nwords, input bit expect_ok);
        logic [63:0] w;
        for (int i = 0; i < nwords; i++) begin
            w = (i == 0) ? mkw(tag, i, len) : mkw(tag, i, 8'hEE);
            if (expect_ok) exp_q.push_back(w);
            send(i == 0, i == nwords - 1, w);
        end
        $display("pkt tag=%h len=%0d words=%0d expect_ok=%0b", tag, len, nwords, expect_ok);
    endtask

    task automatic pop_word(output logic [63:0] d, output logic was_empty);
        was_empty  = fifo_empty;
        d          = fifo_data;
        fifo_rdreq = 1'b1;
        @(posedge clk); #1;
        fifo_rdreq = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (fifo_empty !== 1'b1) begin errors++; $display("FAIL reset_empty got=%0b exp=1", fifo_empty); end
        checks++; if (fifo_data !== 64'h0) begin errors++; $display("FAIL reset_data got=%h exp=0", fifo_data); end
        checks++; if (pkt_count !== '0) begin errors++; $display("FAIL reset_pkt_count got=%0d exp=0", pkt_count); end
        checks++; if (drop_count !== 16'h0) begin errors++; $display("FAIL reset_drop_count got=%0d exp=0", drop_count); end
        checks++; if (err_len !== 1'b0) begin errors++; $display("FAIL reset_err_len got=%0b exp=0", err_len); end
    endtask

    task automatic test_basic();
        logic [63:0] w, got, exp_w;
        logic was_empty;
        for (int i = 0; i < 4; i++) begin
            w = (i == 0) ? mkw(8'h11, i, 8'd4) : mkw(8'h11, i, 8'hEE);
            exp_q.push_back(w);
            send(i == 0, i == 3, w);
            if (i == 2) begin
                checks++; if (fifo_empty !== 1'b1) begin errors++; $display("FAIL basic_partial_hidden got=%0b exp=1", fifo_empty); end
            end
        end
        $display("pkt tag=11 len=4 words=4 expect_ok=1");
        checks++; if (fifo_empty !== 1'b0) begin errors++; $display("FAIL basic_commit_latency got=%0b exp=0", fifo_empty); end
        checks++; if (fifo_data !== exp_q[0]) begin errors++; $display("FAIL basic_head got=%h exp=%h", fifo_data, exp_q[0]); end
        checks++; if (pkt_count !== 5'd1) begin errors++; $display("FAIL basic_pkt_count got=%0d exp=1", pkt_count); end
        for (int i = 0; i < 4; i++) begin
            exp_w = exp_q.pop_front();
            pop_word(got, was_empty);
            checks++;
            if (was_empty || got !== exp_w) begin errors++; $display("FAIL basic_pop%0d got=%h empty=%0b exp=%h", i, got, was_empty, exp_w); end
            if (i == 0) begin
                checks++; if (pkt_count !== 5'd0) begin errors++; $display("FAIL basic_pkt_after_hdr got=%0d exp=0", pkt_count); end
            end
        end
        checks++; if (fifo_empty !== 1'b1) begin errors++; $display("FAIL basic_empty_after got=%0b exp=1", fifo_empty); end
    endtask

    task automatic test_overflow();
        logic [63:0] got, exp_w;
        logic was_empty;
        send_pkt(8'h21, 8'd10, 10, 1'b1);
        send_pkt(8'h22, 8'd7, 7, 1'b0);
        exp_drops++;
        checks++; if (drop_count !== 16'(exp_drops)) begin errors++; $display("FAIL ovf_drop got=%0d exp=%0d", drop_count, exp_drops); end
        checks++; if (pkt_count !== 5'd1) begin errors++; $display("FAIL ovf_pkt_count got=%0d exp=1", pkt_count); end
        send_pkt(8'h23, 8'd6, 6, 1'b1);
        checks++; if (pkt_count !== 5'd2) begin errors++; $display("FAIL ovf_exact_full got=%0d exp=2", pkt_count); end
        send_pkt(8'h24, 8'd1, 1, 1'b0);
        exp_drops++;
        checks++; if (drop_count !== 16'(exp_drops)) begin errors++; $display("FAIL ovf_full_drop got=%0d exp=%0d", drop_count, exp_drops); end
        checks++; if (err_len !== 1'b0) begin errors++; $display("FAIL ovf_err_len got=%0b exp=0", err_len); end
        while (exp_q.size() > 0) begin
            exp_w = exp_q.pop_front();
            pop_word(got, was_empty);
            checks++;
            if (was_empty || got !== exp_w) begin errors++; $display("FAIL ovf_data got=%h empty=%0b exp=%h", got, was_empty, exp_w); end
        end
        checks++; if (fifo_empty !== 1'b1) begin errors++; $display("FAIL ovf_empty_after got=%0b exp=1", fifo_empty); end
    endtask

    task automatic test_len_mismatch();
        logic [63:0] got, exp_w;
        logic was_empty;
        send_pkt(8'h31, 8'd5, 3, 1'b0);
        exp_drops++;
        checks++; if (err_len !== 1'b1) begin errors++; $display("FAIL len_err_len got=%0b exp=1", err_len); end
        checks++; if (drop_count !== 16'(exp_drops)) begin errors++; $display("FAIL len_drop got=%0d exp=%0d", drop_count, exp_drops); end
        checks++; if (fifo_empty !== 1'b1) begin errors++; $display("FAIL len_empty got=%0b exp=1", fifo_empty); end
        send_pkt(8'h32, 8'd2, 2, 1'b1);
        checks++; if (pkt_count !== 5'd1) begin errors++; $display("FAIL len_next_pkt got=%0d exp=1", pkt_count); end
        while (exp_q.size() > 0) begin
            exp_w = exp_q.pop_front();
            pop_word(got, was_empty);
            checks++;
            if (was_empty || got !== exp_w) begin errors++; $display("FAIL len_data got=%h empty=%0b exp=%h", got, was_empty, exp_w); end
        end
    endtask

    task automatic test_sop_abort();
        logic [63:0] w, got, exp_w;
        logic was_empty;
        send(1'b1, 1'b0, mkw(8'h41, 0, 8'd3));
        w = mkw(8'h42, 0, 8'd2);
        exp_q.push_back(w);
        send(1'b1, 1'b0, w);
        w = mkw(8'h42, 1, 8'hEE);
        exp_q.push_back(w);
        send(1'b0, 1'b1, w);
        $display("pkt tag=41 aborted by tag=42 len=2");
        exp_drops++;
        checks++; if (drop_count !== 16'(exp_drops)) begin errors++; $display("FAIL abort_drop got=%0d exp=%0d", drop_count, exp_drops); end
        checks++; if (pkt_count !== 5'd1) begin errors++; $display("FAIL abort_pkt_count got=%0d exp=1", pkt_count); end
        while (exp_q.size() > 0) begin
            exp_w = exp_q.pop_front();
            pop_word(got, was_empty);
            checks++;
            if (was_empty || got !== exp_w) begin errors++; $display("FAIL abort_data got=%h empty=%0b exp=%h", got, was_empty, exp_w); end
        end
    endtask

    task automatic test_stream();
        logic [63:0] w, got, exp_w;
        logic was_empty;
        int popped = 0;
        for (int i = 0; i < 40; i++) begin
            w = mkw(8'h51, i, 8'd1);
            exp_q.push_back(w);
            in_valid = 1'b1; in_sop = 1'b1; in_eop = 1'b1; in_data = w;
            fifo_rdreq = 1'b1;
            if (!fifo_empty) begin
                exp_w = exp_q.pop_front();
                popped++;
                checks++; if (fifo_data !== exp_w) begin errors++; $display("FAIL stream_data got=%h exp=%h", fifo_data, exp_w); end
            end
            checks++; if (pkt_count > 5'd1) begin errors++; $display("FAIL stream_pkt_count got=%0d exp<=1", pkt_count); end
            @(posedge clk); #1;
        end
        in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_data = '0;
        fifo_rdreq = 1'b0;
        $display("stream 40 one-word packets with continuous read");
        while (exp_q.size() > 0) begin
            exp_w = exp_q.pop_front();
            pop_word(got, was_empty);
            popped++;
            checks++;
            if (was_empty || got !== exp_w) begin errors++; $display("FAIL stream_tail got=%h empty=%0b exp=%h", got, was_empty, exp_w); end
        end
        checks++; if (popped != 40) begin errors++; $display("FAIL stream_count got=%0d exp=40", popped); end
        checks++; if (fifo_empty !== 1'b1) begin errors++; $display("FAIL stream_empty got=%0b exp=1", fifo_empty); end
    endtask

    task automatic test_reset_mid();
        logic [63:0] got, exp_w;
        logic was_empty;
        send_pkt(8'h61, 8'd1, 1, 1'b1);
        send_pkt(8'h62, 8'd2, 2, 1'b1);
        checks++; if (pkt_count !== 5'd2) begin errors++; $display("FAIL rstmid_pkt_before got=%0d exp=2", pkt_count); end
        send(1'b1, 1'b0, mkw(8'h63, 0, 8'd4));
        send(1'b0, 1'b0, mkw(8'h63, 1, 8'hEE));
        #2 rst_n = 1'b0;
        #1;
        $display("async reset asserted mid-packet");
        checks++; if (fifo_empty !== 1'b1) begin errors++; $display("FAIL rstmid_empty got=%0b exp=1", fifo_empty); end
        checks++; if (fifo_data !== 64'h0) begin errors++; $display("FAIL rstmid_data got=%h exp=0", fifo_data); end
        checks++; if (pkt_count !== '0) begin errors++; $display("FAIL rstmid_pkt_count got=%0d exp=0", pkt_count); end
        checks++; if (drop_count !== 16'h0) begin errors++; $display("FAIL rstmid_drop got=%0d exp=0", drop_count); end
        checks++; if (err_len !== 1'b0) begin errors++; $display("FAIL rstmid_err_len got=%0b exp=0", err_len); end
        exp_q.delete();
        exp_drops = 0;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        send_pkt(8'h64, 8'd3, 3, 1'b1);
        checks++; if (pkt_count !== 5'd1) begin errors++; $display("FAIL rstmid_next_pkt got=%0d exp=1", pkt_count); end
        while (exp_q.size() > 0) begin
            exp_w = exp_q.pop_front();
            pop_word(got, was_empty);
            checks++;
            if (was_empty || got !== exp_w) begin errors++; $display("FAIL rstmid_data_after got=%h empty=%0b exp=%h", got, was_empty, exp_w); end
        end
        checks++; if (drop_count !== 16'(exp_drops)) begin errors++; $display("FAIL rstmid_drop_after got=%0d exp=%0d", drop_count, exp_drops); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_len_mismatch();
        test_sop_abort();
        test_stream();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
